dtcm_arbiter: RTL and testbench
===============================

# dtcm_arbiter

Two-requester arbiter sharing the single-port DTCM between the LSU control path and an external/debug bus master. It forwards one command per cycle to the DTCM and tracks the single outstanding transaction. It routes the DTCM response, which arrives one cycle after the command, back to the requester that issued it. LSU has default priority; a starvation counter guarantees the external port a grant after a bounded number of consecutive LSU grants.

## Interface
- AW, default `DTCM_ADDR_WIDTH: command address width
- DW, default `XLEN: data width; mask width is DW/8
- STARVE_MAX, default 4: consecutive LSU grants allowed while ext is waiting; range 1..15
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lsu_cmd_valid / lsu_cmd_ready  in/out  1  LSU command handshake
- lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_wmask  in  1/AW/DW/DW/8  LSU command payload
- lsu_rsp_valid / lsu_rsp_ready  out/in  1  LSU response handshake
- lsu_rsp_rdata  out  DW  LSU response data
- ext_cmd_valid / ext_cmd_ready, ext_cmd_read, ext_cmd_addr, ext_cmd_wdata, ext_cmd_wmask  same as LSU, for the external port
- ext_rsp_valid / ext_rsp_ready, ext_rsp_rdata  same as LSU, for the external port
- dtcm_cmd_valid / dtcm_cmd_ready  out/in  1  DTCM command handshake
- dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask  out  1/AW/DW/DW/8  granted payload
- dtcm_rsp_valid / dtcm_rsp_ready  in/out  1  DTCM response handshake
- dtcm_rsp_rdata  in  DW  DTCM read data

## Operation
- State registers:
  - pend (1 b): a transaction is outstanding.
  - owner (1 b): 0 = LSU, 1 = ext.
  - starve_cnt (4 b).
- Issue window: `can_issue = !pend | (dtcm_rsp_valid & dtcm_rsp_ready)`.
- Grant (combinational):
  - `sel_ext = ext_cmd_valid & (!lsu_cmd_valid | starve_cnt == STARVE_MAX)`.
  - Otherwise LSU is selected.
- Command path:
  - `dtcm_cmd_valid = can_issue & (sel_ext ? ext_cmd_valid : lsu_cmd_valid)`.
  - The payload is muxed from the selected port.
  - Only the selected port's cmd_ready equals `dtcm_cmd_ready & can_issue`; the other port's cmd_ready is 0.
- Command handshake (cmd_fire = dtcm_cmd_valid & dtcm_cmd_ready):
  - pend <= 1.
  - owner <= sel_ext.
- Response completion without a new fire: pend <= 0.
- Response routing:
  - `lsu_rsp_valid = dtcm_rsp_valid & pend & !owner`.
  - `ext_rsp_valid = dtcm_rsp_valid & pend & owner`.
  - rdata is broadcast to both ports, gated to 0 when the port's rsp_valid is 0.
  - dtcm_rsp_ready equals the owner's rsp_ready when pend is 1, and 1 when pend is 0.
- Spurious responses: a DTCM response with pend = 0 is consumed and dropped.
- Starvation counter:
  - On cmd_fire for LSU while ext_cmd_valid is 1: starve_cnt increments, saturating at STARVE_MAX.
  - On cmd_fire for ext, or in any cycle with ext_cmd_valid = 0: starve_cnt <= 0.
  - Otherwise starve_cnt holds.
- Write and read commands follow identical rules. Writes also produce a DTCM response and occupy pend.

## Timing
- Reset values:
  - pend = 0, owner = 0, starve_cnt = 0.
  - All rsp_valid outputs 0; dtcm_cmd_valid follows the inputs combinationally.
- Command path latency: zero cycles, combinational. Response path latency: zero cycles, combinational.
- End-to-end latency: one cycle from command fire to response, given the DTCM's one-cycle return.
- Throughput: one command per cycle when the owner's rsp_ready is held high. A response completing in cycle N permits a new fire in the same cycle N.
- Owner back-pressure: if the owner holds rsp_ready low, dtcm_rsp_ready is low, can_issue is 0, and both cmd_ready outputs stay 0 until the response is accepted.
- Requester obligation: requesters hold valid and payload stable until ready.
- Stall behaviour: the grant may switch to LSU while ext is stalled, because LSU can arrive later and has priority. The DTCM therefore must not depend on payload stability while dtcm_cmd_ready is low.
- Simultaneous valids with starve_cnt < STARVE_MAX: LSU is granted. At starve_cnt = STARVE_MAX: ext is granted.
- Reset mid-transaction:
  - pend is cleared immediately.
  - A DTCM response in the first cycle after reset is dropped and not forwarded.

## Test plan
- LSU read to addr 0x10, DTCM returns 0xDEADBEEF next cycle -> lsu_rsp_valid = 1 with rdata 0xDEADBEEF; ext_rsp_valid stays 0.
- LSU and ext both continuously valid, STARVE_MAX = 4, dtcm_cmd_ready = 1, all rsp_ready = 1 -> grant order L,L,L,L,E,L,L,L,L,E; one fire per cycle.
- ext write in cycle 0; ext_rsp_ready low for cycles 1-3 -> no cmd_ready on either port in cycles 1-3; pend stays 1; the next fire occurs in cycle 4 with the response consumed that cycle.
- dtcm_cmd_ready low for 3 cycles with LSU valid; ext becomes valid in the 2nd cycle -> LSU is still selected; ext_cmd_ready stays 0; the LSU fire occurs when ready rises; starve_cnt = 1.
- rst_n asserted with pend = 1, then a DTCM response arrives after reset -> dtcm_rsp_ready = 1; lsu_rsp_valid = ext_rsp_valid = 0; starve_cnt = 0.
- Back-to-back LSU reads, then an ext read arriving when ext_cmd_valid had been low -> starve_cnt resets to 0 on the valid-low cycles; ext is granted only when LSU is idle.

Source files
------------

// File: rtl/dtcm_arbiter_if.sv
// ---------------------------------------------------------------------------
// dtcm_arbiter_if
//   One DTCM-style command/response channel. It is used for the two requester
//   ports (LSU and external/debug master) and for the downstream DTCM port.
//
//   Command : cmd_valid/cmd_ready handshake with the payload cmd_read,
//             cmd_addr, cmd_wdata and cmd_wmask.
//   Response: rsp_valid/rsp_ready handshake with rsp_rdata.
//
//   modport master : the side that issues commands and consumes responses
//   modport slave  : the side that accepts commands and returns responses
// ---------------------------------------------------------------------------
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface dtcm_arbiter_if #(
  parameter int AW = `DTCM_ADDR_WIDTH,
  parameter int DW = `XLEN
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_read;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic [DW/8-1:0]   cmd_wmask;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dtcm_arbiter.sv
// ---------------------------------------------------------------------------
// dtcm_arbiter
//   Shares the single-port DTCM between the LSU control path and an
//   external/debug bus master. At most one command is forwarded per cycle.
//   Exactly one transaction is tracked while it is outstanding, and the DTCM
//   response is returned to whichever requester issued that transaction.
//   LSU wins by default. A starvation counter makes sure that a waiting
//   external master is granted after STARVE_MAX consecutive LSU grants.
//
//   Ports
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     lsu   : LSU requester port (slave modport)
//     ext   : external/debug requester port (slave modport)
//     dtcm  : downstream DTCM port (master modport); the DTCM returns the
//             response one cycle after the command
//
//   Parameters
//     AW         : command address width
//     DW         : data width; the write mask is DW/8 bits wide
//     STARVE_MAX : consecutive LSU grants allowed while ext waits (1..15)
// ---------------------------------------------------------------------------
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef XLEN
`define XLEN 32
`endif

module dtcm_arbiter #(
  parameter int AW         = `DTCM_ADDR_WIDTH,
  parameter int DW         = `XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dtcm_arbiter_if.slave  lsu,
  dtcm_arbiter_if.slave  ext,
  dtcm_arbiter_if.master dtcm
);

  typedef enum logic {
    OWNER_LSU = 1'b0,
    OWNER_EXT = 1'b1
  } owner_e;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  // State
  logic       pend_q,       pend_d;
  owner_e     owner_q,      owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Combinational internals
  logic            rsp_ready;
  logic            rsp_fire;
  logic            can_issue;
  logic            sel_ext;
  logic            cmd_fire;
  logic            sel_valid;
  logic            sel_read;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_wmask;
  logic            lsu_rsp_valid;
  logic            ext_rsp_valid;

  // Response side. While no transaction is outstanding the DTCM is always
  // allowed to hand over a response, so that a stray response is absorbed
  // instead of blocking the port.
  always_comb begin
    rsp_ready = 1'b1;
    if (pend_q) begin
      rsp_ready = (owner_q == OWNER_EXT) ? ext.rsp_ready : lsu.rsp_ready;
    end
    rsp_fire      = dtcm.rsp_valid & rsp_ready;
    lsu_rsp_valid = dtcm.rsp_valid & pend_q & (owner_q == OWNER_LSU);
    ext_rsp_valid = dtcm.rsp_valid & pend_q & (owner_q == OWNER_EXT);
  end

  // Grant and command mux. A new command may go out in the same cycle in
  // which the outstanding response completes, which sustains one command
  // per cycle. The grant is recomputed every cycle and may move to LSU while
  // ext is stalled, so the DTCM must not assume the payload stays stable
  // while it holds cmd_ready low.
  always_comb begin
    can_issue = ~pend_q | rsp_fire;
    sel_ext   = ext.cmd_valid & (~lsu.cmd_valid | (starve_cnt_q == STARVE_LIMIT));

    sel_valid = lsu.cmd_valid;
    sel_read  = lsu.cmd_read;
    sel_addr  = lsu.cmd_addr;
    sel_wdata = lsu.cmd_wdata;
    sel_wmask = lsu.cmd_wmask;
    if (sel_ext) begin
      sel_valid = ext.cmd_valid;
      sel_read  = ext.cmd_read;
      sel_addr  = ext.cmd_addr;
      sel_wdata = ext.cmd_wdata;
      sel_wmask = ext.cmd_wmask;
    end

    cmd_fire = can_issue & sel_valid & dtcm.cmd_ready;
  end

  // Next-state logic. When a response completes and a new command fires in
  // the same cycle, the new command takes precedence and pend stays set.
  // The starvation counter only counts LSU grants that were taken while
  // ext was actually waiting. It is cleared whenever ext is granted, or
  // whenever ext is not requesting.
  always_comb begin
    pend_d       = pend_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;

    if (cmd_fire) begin
      pend_d  = 1'b1;
      owner_d = sel_ext ? OWNER_EXT : OWNER_LSU;
    end else if (rsp_fire) begin
      pend_d  = 1'b0;
    end

    if (cmd_fire & sel_ext) begin
      starve_cnt_d = 4'd0;
    end else if (~ext.cmd_valid) begin
      starve_cnt_d = 4'd0;
    end else if (cmd_fire) begin
      if (starve_cnt_q < STARVE_LIMIT) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      owner_q      <= OWNER_LSU;
      starve_cnt_q <= 4'd0;
    end else begin
      pend_q       <= pend_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // DTCM command port
  assign dtcm.cmd_valid = can_issue & sel_valid;
  assign dtcm.cmd_read  = sel_read;
  assign dtcm.cmd_addr  = sel_addr;
  assign dtcm.cmd_wdata = sel_wdata;
  assign dtcm.cmd_wmask = sel_wmask;
  assign dtcm.rsp_ready = rsp_ready;

  // Requester command ready: only the selected port ever sees ready
  assign lsu.cmd_ready = dtcm.cmd_ready & can_issue & ~sel_ext;
  assign ext.cmd_ready = dtcm.cmd_ready & can_issue & sel_ext;

  // Requester responses. Read data is shared by both ports but forced to
  // zero on the port that does not own the response.
  assign lsu.rsp_valid = lsu_rsp_valid;
  assign ext.rsp_valid = ext_rsp_valid;
  assign lsu.rsp_rdata = lsu_rsp_valid ? dtcm.rsp_rdata : '0;
  assign ext.rsp_rdata = ext_rsp_valid ? dtcm.rsp_rdata : '0;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dtcm_arbiter
//   Directed bench for dtcm_arbiter. The inputs are driven on the falling
//   edge, the outputs are sampled 1 ns later, and the state updates on the
//   following rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dtcm_arbiter;

  localparam int AW         = 16;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  dtcm_arbiter_if #(.AW(AW), .DW(DW)) lsu_if ();
  dtcm_arbiter_if #(.AW(AW), .DW(DW)) ext_if ();
  dtcm_arbiter_if #(.AW(AW), .DW(DW)) dtcm_if ();

  dtcm_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .lsu  (lsu_if),
    .ext  (ext_if),
    .dtcm (dtcm_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, then let the logic settle
  task automatic applyStimulus(input logic rst, input logic lsu_v, input logic ext_v,
                               input logic cmd_rdy, input logic rsp_v,
                               input logic [DW-1:0] rdata,
                               input logic lsu_rr, input logic ext_rr);
    @(negedge clk);
    rst_n              = rst;
    lsu_if.cmd_valid   = lsu_v;
    ext_if.cmd_valid   = ext_v;
    dtcm_if.cmd_ready  = cmd_rdy;
    dtcm_if.rsp_valid  = rsp_v;
    dtcm_if.rsp_rdata  = rdata;
    lsu_if.rsp_ready   = lsu_rr;
    ext_if.rsp_ready   = ext_rr;
    #1;
  endtask

  logic exp_ext [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    lsu_if.cmd_valid = 1'b0; lsu_if.cmd_read = 1'b1; lsu_if.cmd_addr = 16'h0010;
    lsu_if.cmd_wdata = '0;   lsu_if.cmd_wmask = 4'h0; lsu_if.rsp_ready = 1'b0;
    ext_if.cmd_valid = 1'b0; ext_if.cmd_read = 1'b1; ext_if.cmd_addr = 16'h0200;
    ext_if.cmd_wdata = '0;   ext_if.cmd_wmask = 4'h0; ext_if.rsp_ready = 1'b0;
    dtcm_if.cmd_ready = 1'b0; dtcm_if.rsp_valid = 1'b0; dtcm_if.rsp_rdata = '0;

    // Reset state
    applyStimulus(1'b0, 0, 0, 0, 0, '0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, '0, 0, 0);
    checkOutput("rst_pend",       dut.pend_q,        1'b0);
    checkOutput("rst_starve",     dut.starve_cnt_q,  4'd0);
    checkOutput("rst_lsu_rspv",   lsu_if.rsp_valid,  1'b0);
    checkOutput("rst_ext_rspv",   ext_if.rsp_valid,  1'b0);
    checkOutput("rst_dtcm_rsprdy", dtcm_if.rsp_ready, 1'b1);
    checkOutput("rst_cmdv",       dtcm_if.cmd_valid, 1'b0);

    // LSU read of 0x10, response 0xDEADBEEF on the next cycle
    applyStimulus(1'b1, 1, 0, 1, 0, '0, 1, 1);
    checkOutput("rd_cmdv",     dtcm_if.cmd_valid, 1'b1);
    checkOutput("rd_addr",     dtcm_if.cmd_addr,  16'h0010);
    checkOutput("rd_read",     dtcm_if.cmd_read,  1'b1);
    checkOutput("rd_lsu_rdy",  lsu_if.cmd_ready,  1'b1);
    checkOutput("rd_ext_rdy",  ext_if.cmd_ready,  1'b0);
    applyStimulus(1'b1, 0, 0, 1, 1, 32'hDEADBEEF, 1, 1);
    checkOutput("rd_lsu_rspv", lsu_if.rsp_valid,  1'b1);
    checkOutput("rd_lsu_data", lsu_if.rsp_rdata,  32'hDEADBEEF);
    checkOutput("rd_ext_rspv", ext_if.rsp_valid,  1'b0);
    checkOutput("rd_ext_data", ext_if.rsp_rdata,  32'h0);
    applyStimulus(1'b1, 0, 0, 1, 0, '0, 1, 1);
    checkOutput("rd_pend_clr", dut.pend_q, 1'b0);

    // Both ports continuously valid: expected order L,L,L,L,E,L,L,L,L,E
    lsu_if.cmd_addr = 16'h0100;
    ext_if.cmd_addr = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1, 1, 1, (i > 0), 32'hA0000000 + i, 1, 1);
      checkOutput($sformatf("rr%0d_ext_rdy", i), ext_if.cmd_ready, exp_ext[i]);
      checkOutput($sformatf("rr%0d_lsu_rdy", i), lsu_if.cmd_ready, !exp_ext[i]);
      checkOutput($sformatf("rr%0d_addr", i), dtcm_if.cmd_addr,
                  exp_ext[i] ? 16'h0200 : 16'h0100);
      if (i > 0) begin
        checkOutput($sformatf("rr%0d_lsu_rspv", i), lsu_if.rsp_valid, !exp_ext[i-1]);
        checkOutput($sformatf("rr%0d_ext_rspv", i), ext_if.rsp_valid, exp_ext[i-1]);
      end
    end
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h00005555, 1, 1);
    checkOutput("rr_drain_ext_rspv", ext_if.rsp_valid, 1'b1);
    checkOutput("rr_drain_ext_data", ext_if.rsp_rdata, 32'h00005555);
    checkOutput("rr_drain_lsu_rspv", lsu_if.rsp_valid, 1'b0);

    // ext write, then ext holds rsp_ready low for three cycles
    ext_if.cmd_read  = 1'b0;
    ext_if.cmd_addr  = 16'h0044;
    ext_if.cmd_wdata = 32'h12345678;
    ext_if.cmd_wmask = 4'h3;
    lsu_if.cmd_addr  = 16'h0080;
    applyStimulus(1'b1, 0, 1, 1, 0, '0, 1, 1);
    checkOutput("wr_ext_rdy", ext_if.cmd_ready,  1'b1);
    checkOutput("wr_read",    dtcm_if.cmd_read,  1'b0);
    checkOutput("wr_wdata",   dtcm_if.cmd_wdata, 32'h12345678);
    checkOutput("wr_wmask",   dtcm_if.cmd_wmask, 4'h3);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, 1, 0, 1, 1, '0, 1, 0);
      checkOutput($sformatf("bp%0d_lsu_rdy", c),  lsu_if.cmd_ready,  1'b0);
      checkOutput($sformatf("bp%0d_ext_rdy", c),  ext_if.cmd_ready,  1'b0);
      checkOutput($sformatf("bp%0d_rsprdy", c),   dtcm_if.rsp_ready, 1'b0);
      checkOutput($sformatf("bp%0d_cmdv", c),     dtcm_if.cmd_valid, 1'b0);
      checkOutput($sformatf("bp%0d_pend", c),     dut.pend_q,        1'b1);
    end
    applyStimulus(1'b1, 1, 0, 1, 1, '0, 1, 1);
    checkOutput("bp4_rsprdy",   dtcm_if.rsp_ready, 1'b1);
    checkOutput("bp4_ext_rspv", ext_if.rsp_valid,  1'b1);
    checkOutput("bp4_lsu_rdy",  lsu_if.cmd_ready,  1'b1);
    checkOutput("bp4_addr",     dtcm_if.cmd_addr,  16'h0080);
    applyStimulus(1'b1, 0, 0, 1, 1, 32'hCAFE0001, 1, 1);
    checkOutput("bp5_lsu_rspv", lsu_if.rsp_valid,  1'b1);
    checkOutput("bp5_lsu_data", lsu_if.rsp_rdata,  32'hCAFE0001);
    applyStimulus(1'b1, 0, 0, 1, 0, '0, 1, 1);
    checkOutput("bp6_pend", dut.pend_q, 1'b0);

    // dtcm_cmd_ready low for three cycles; ext arrives in the second one
    lsu_if.cmd_read = 1'b1; lsu_if.cmd_addr = 16'h0090;
    ext_if.cmd_read = 1'b1; ext_if.cmd_addr = 16'h002C;
    applyStimulus(1'b1, 1, 0, 0, 0, '0, 1, 1);
    checkOutput("st0_cmdv",    dtcm_if.cmd_valid, 1'b1);
    checkOutput("st0_lsu_rdy", lsu_if.cmd_ready,  1'b0);
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(1'b1, 1, 1, 0, 0, '0, 1, 1);
      checkOutput($sformatf("st%0d_addr", c),    dtcm_if.cmd_addr, 16'h0090);
      checkOutput($sformatf("st%0d_ext_rdy", c), ext_if.cmd_ready, 1'b0);
      checkOutput($sformatf("st%0d_lsu_rdy", c), lsu_if.cmd_ready, 1'b0);
    end
    applyStimulus(1'b1, 1, 1, 1, 0, '0, 1, 1);
    checkOutput("st3_lsu_rdy", lsu_if.cmd_ready, 1'b1);
    checkOutput("st3_ext_rdy", ext_if.cmd_ready, 1'b0);
    applyStimulus(1'b1, 0, 1, 1, 1, 32'h0BADF00D, 1, 1);
    checkOutput("st4_starve",   dut.starve_cnt_q, 4'd1);
    checkOutput("st4_ext_rdy",  ext_if.cmd_ready, 1'b1);
    checkOutput("st4_addr",     dtcm_if.cmd_addr, 16'h002C);
    checkOutput("st4_lsu_rspv", lsu_if.rsp_valid, 1'b1);
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h00C0FFEE, 1, 1);
    checkOutput("st5_ext_rspv", ext_if.rsp_valid, 1'b1);
    checkOutput("st5_ext_data", ext_if.rsp_rdata, 32'h00C0FFEE);
    checkOutput("st5_starve",   dut.starve_cnt_q, 4'd0);

    // Reset while a transaction is outstanding
    applyStimulus(1'b1, 1, 1, 1, 0, '0, 1, 1);
    applyStimulus(1'b0, 0, 0, 0, 1, 32'h00000077, 1, 1);
    checkOutput("mrst_pend",     dut.pend_q,        1'b0);
    checkOutput("mrst_starve",   dut.starve_cnt_q,  4'd0);
    checkOutput("mrst_lsu_rspv", lsu_if.rsp_valid,  1'b0);
    applyStimulus(1'b1, 0, 0, 0, 1, 32'h00000088, 1, 1);
    checkOutput("mrst_rsprdy",   dtcm_if.rsp_ready, 1'b1);
    checkOutput("mrst_lsu_rspv2", lsu_if.rsp_valid, 1'b0);
    checkOutput("mrst_ext_rspv2", ext_if.rsp_valid, 1'b0);
    checkOutput("mrst_lsu_data", lsu_if.rsp_rdata,  32'h0);
    applyStimulus(1'b1, 0, 0, 0, 0, '0, 1, 1);

    // Back-to-back LSU reads; ext requests only later
    lsu_if.cmd_addr = 16'h0100;
    applyStimulus(1'b1, 1, 0, 1, 0, '0, 1, 1);
    checkOutput("b2b0_starve", dut.starve_cnt_q, 4'd0);
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(1'b1, 1, 0, 1, 1, '0, 1, 1);
      checkOutput($sformatf("b2b%0d_lsu_rdy", c), lsu_if.cmd_ready, 1'b1);
      checkOutput($sformatf("b2b%0d_starve", c),  dut.starve_cnt_q, 4'd0);
    end
    applyStimulus(1'b1, 1, 1, 1, 1, '0, 1, 1);
    checkOutput("b2b3_ext_rdy", ext_if.cmd_ready, 1'b0);
    checkOutput("b2b3_lsu_rdy", lsu_if.cmd_ready, 1'b1);
    applyStimulus(1'b1, 0, 1, 1, 1, '0, 1, 1);
    checkOutput("b2b4_starve",  dut.starve_cnt_q, 4'd1);
    checkOutput("b2b4_ext_rdy", ext_if.cmd_ready, 1'b1);
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h00000ABC, 1, 1);
    checkOutput("b2b5_ext_rspv", ext_if.rsp_valid, 1'b1);

    // Spurious DTCM response while idle is absorbed and not forwarded
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h0000FFFF, 1, 0);
    checkOutput("spur_rsprdy",   dtcm_if.rsp_ready, 1'b1);
    checkOutput("spur_lsu_rspv", lsu_if.rsp_valid,  1'b0);
    checkOutput("spur_ext_rspv", ext_if.rsp_valid,  1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
